// File: rtl/williams_video_pkg.sv
// rtl/williams_video_pkg.sv - default Williams timing constants and threshold helper
package williams_video_pkg;

  localparam int DEF_CE_DIV_LOG2 = 1;
  localparam int DEF_PCNT_W      = 11;
  localparam int DEF_LCNT_W      = 11;
  localparam int DEF_HPOS_W      = DEF_PCNT_W - DEF_CE_DIV_LOG2;
  localparam int DEF_HB_START    = 336;
  localparam int DEF_HB_END      = 40;
  localparam int DEF_VB_START    = 246;
  localparam int DEF_VB_END      = 6;
  localparam int DEF_ADJ_W       = 4;

  // Constant plus signed offset, wrapped to a counter of the given width (no clamping).
  function automatic logic [31:0] wrap_thresh(input logic [31:0] base,
                                              input logic signed [31:0] adj,
                                              input int width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (base + adj) & mask;
  endfunction

endpackage

// File: rtl/williams_video_timing_if.sv
// rtl/williams_video_timing_if.sv - video timing outputs bundle towards arcade_video
interface williams_video_timing_if
  import williams_video_pkg::*;
#(
  parameter int HPOS_W = DEF_HPOS_W,
  parameter int VPOS_W = DEF_LCNT_W
);
  logic              ce_pix;
  logic              hblank;
  logic              vblank;
  logic              de;
  logic              frame_start;
  logic [HPOS_W-1:0] hpos;
  logic [VPOS_W-1:0] vpos;

  modport master (output ce_pix, hblank, vblank, de, frame_start, hpos, vpos);
  modport slave  (input  ce_pix, hblank, vblank, de, frame_start, hpos, vpos);
endinterface

// File: rtl/williams_sync_edge.sv
// rtl/williams_sync_edge.sv - sync register plus polarity-aware active-edge detect
module williams_sync_edge #(
  parameter bit POL = 1'b1
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic sync_in,
  output logic sync_edge
);
  logic cur_q, cur_d;
  logic prev_q, prev_d;

  // Next values: sample the raw sync once, keep one older copy for the edge compare.
  always_comb begin
    cur_d  = sync_in;
    prev_d = cur_q;
  end

  // Both stages start at the inactive level so reset never fakes an edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cur_q  <= ~POL;
      prev_q <= ~POL;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  assign sync_edge = (prev_q != POL) && (cur_q == POL);
endmodule

// File: rtl/williams_video_timing.sv
// rtl/williams_video_timing.sv - ce_pix/blanking/de/frame_start from raw hs/vs
// Optional measurement outputs (line_len, frame_lines, timing_stable): VIDEO_TIMING_MEASURE_EN
module williams_video_timing
  import williams_video_pkg::*;
#(
  parameter int CE_DIV_LOG2 = DEF_CE_DIV_LOG2,
  parameter int PCNT_W      = DEF_PCNT_W,
  parameter int LCNT_W      = DEF_LCNT_W,
  parameter int HB_START    = DEF_HB_START,
  parameter int HB_END      = DEF_HB_END,
  parameter int VB_START    = DEF_VB_START,
  parameter int VB_END      = DEF_VB_END,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int ADJ_W       = DEF_ADJ_W
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [ADJ_W-1:0] h_adj,
  input  logic [ADJ_W-1:0] v_adj,
  williams_video_timing_if.master vid
`ifdef VIDEO_TIMING_MEASURE_EN
  ,
  output logic [PCNT_W-1:0] line_len,
  output logic [LCNT_W-1:0] frame_lines,
  output logic              timing_stable
`endif
);
  localparam int HPOS_W = PCNT_W - CE_DIV_LOG2;

  logic              hs_edge, vs_edge, frame_edge;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic [ADJ_W-1:0]  h_adj_q, h_adj_d, v_adj_q, v_adj_d;
  logic              hblank_q, hblank_d, vblank_q, vblank_d;
  logic              de_q, de_d, frame_start_q, frame_start_d;
  logic              pcnt_sat, lcnt_sat, ce;
  logic [HPOS_W-1:0] hpos_w;
  logic signed [31:0] h_adj_se, v_adj_se;
  logic [31:0]       hb_start_t, hb_end_t, vb_start_t, vb_end_t;

  williams_sync_edge #(.POL(HS_POL)) u_hs_edge (
    .clk_sys(clk_sys), .reset_n(reset_n), .sync_in(hs_in), .sync_edge(hs_edge)
  );
  williams_sync_edge #(.POL(VS_POL)) u_vs_edge (
    .clk_sys(clk_sys), .reset_n(reset_n), .sync_in(vs_in), .sync_edge(vs_edge)
  );

  // A vs edge only counts when it lands on an hs-edge cycle.
  assign frame_edge = hs_edge && vs_edge;
  assign pcnt_sat   = &pcnt_q;
  assign lcnt_sat   = &lcnt_q;
  assign hpos_w     = HPOS_W'(pcnt_q >> CE_DIV_LOG2);

  generate
    if (CE_DIV_LOG2 == 0) begin : g_ce_full
      assign ce = !pcnt_sat;
    end else begin : g_ce_div
      assign ce = (&pcnt_q[CE_DIV_LOG2-1:0]) && !pcnt_sat;
    end
  endgenerate

  // Blank thresholds from the frame-latched offsets, wrapped to hpos/vpos width.
  always_comb begin
    h_adj_se   = 32'($signed(h_adj_q));
    v_adj_se   = 32'($signed(v_adj_q));
    hb_start_t = wrap_thresh(32'(HB_START), h_adj_se, HPOS_W);
    hb_end_t   = wrap_thresh(32'(HB_END),   h_adj_se, HPOS_W);
    vb_start_t = wrap_thresh(32'(VB_START), v_adj_se, LCNT_W);
    vb_end_t   = wrap_thresh(32'(VB_END),   v_adj_se, LCNT_W);
  end

  // Counters, offset latches and blank flags; hs reload beats increment, clear beats set.
  always_comb begin
    pcnt_d        = pcnt_q;
    lcnt_d        = lcnt_q;
    h_adj_d       = h_adj_q;
    v_adj_d       = v_adj_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    frame_start_d = 1'b0;
    if (hs_edge) begin
      pcnt_d = '0;
    end else if (!pcnt_sat) begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end
    if (frame_edge) begin
      lcnt_d        = '0;
      h_adj_d       = h_adj;
      v_adj_d       = v_adj;
      frame_start_d = 1'b1;
    end else if (hs_edge && !lcnt_sat) begin
      lcnt_d = lcnt_q + LCNT_W'(1);
    end
    if (!pcnt_sat && (32'(hpos_w) == hb_end_t)) begin
      hblank_d = 1'b0;
    end else if (!pcnt_sat && (32'(hpos_w) == hb_start_t)) begin
      hblank_d = 1'b1;
    end
    if (!lcnt_sat && (32'(lcnt_q) == vb_end_t)) begin
      vblank_d = 1'b0;
    end else if (!lcnt_sat && (32'(lcnt_q) == vb_start_t)) begin
      vblank_d = 1'b1;
    end
    de_d = !hblank_d && !vblank_d;
  end

  // Timing state register; counters come out of reset saturated and blanked.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q        <= '1;
      lcnt_q        <= '1;
      h_adj_q       <= '0;
      v_adj_q       <= '0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      lcnt_q        <= lcnt_d;
      h_adj_q       <= h_adj_d;
      v_adj_q       <= v_adj_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.ce_pix      = ce;
  assign vid.hblank      = hblank_q;
  assign vid.vblank      = vblank_q;
  assign vid.de          = de_q;
  assign vid.frame_start = frame_start_q;
  assign vid.hpos        = hpos_w;
  assign vid.vpos        = lcnt_q;

`ifdef VIDEO_TIMING_MEASURE_EN
  logic [PCNT_W-1:0] line_len_q, line_len_d, line_len_fs_q, line_len_fs_d;
  logic [LCNT_W-1:0] frame_lines_q, frame_lines_d;
  logic              stable_q, stable_d;

  // Line length at every hs edge; frame comparison against the previous frame start.
  always_comb begin
    line_len_d    = line_len_q;
    line_len_fs_d = line_len_fs_q;
    frame_lines_d = frame_lines_q;
    stable_d      = stable_q;
    if (hs_edge) begin
      line_len_d = pcnt_q;
    end
    if (frame_edge) begin
      frame_lines_d = lcnt_q;
      line_len_fs_d = pcnt_q;
      stable_d      = (lcnt_q == frame_lines_q) && (pcnt_q == line_len_fs_q);
    end
    if (pcnt_sat || lcnt_sat) begin
      stable_d = 1'b0;
    end
  end

  // Measurement registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      line_len_q    <= '0;
      line_len_fs_q <= '0;
      frame_lines_q <= '0;
      stable_q      <= 1'b0;
    end else begin
      line_len_q    <= line_len_d;
      line_len_fs_q <= line_len_fs_d;
      frame_lines_q <= frame_lines_d;
      stable_q      <= stable_d;
    end
  end

  assign line_len      = line_len_q;
  assign frame_lines   = frame_lines_q;
  assign timing_stable = stable_q;
`endif
endmodule
